// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle add/sub/logic ops plus an unsigned shift-add
// multiplier retiring STEP multiplier bits per cycle (low or high product half).
module alu_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8) || (WIDTH % STEP) != 0) begin : g_bad_cfg
    $error("alu_iter: illegal WIDTH/STEP combination");
  end

  typedef enum logic {IDLE, MULT} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               hi_q, hi_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic               out_valid_q, out_valid_d;

  logic               alu_is_sub;
  logic [WIDTH-1:0]   alu_b;
  logic [WIDTH:0]     alu_sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;

  logic [2*WIDTH-1:0] pp_term [STEP];
  logic [2*WIDTH-1:0] pp_sum;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mul_res;

  // One shared adder; subtraction folds the +1 into the carry-in.
  always_comb begin
    alu_is_sub = (op == 3'b001);
    alu_b      = alu_is_sub ? ~b : b;
    alu_sum    = {1'b0, a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, alu_is_sub};
    alu_res    = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    case (op)
      3'b000, 3'b001: begin
        alu_res = alu_sum[WIDTH-1:0];
        alu_c   = alu_sum[WIDTH];
        alu_v   = (a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010:  alu_res = a & b;
      3'b011:  alu_res = a | b;
      3'b100:  alu_res = b;
      default: alu_res = '0;
    endcase
  end

  // Multiplicand shifts left and multiplier shifts right, so each cycle only
  // looks at the low STEP multiplier bits.
  for (genvar gi = 0; gi < STEP; gi++) begin : g_pp
    assign pp_term[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
  end

  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < STEP; i++) begin
      pp_sum = pp_sum + pp_term[i];
    end
    acc_sum = acc_q + pp_sum;
    mul_res = hi_q ? acc_sum[2*WIDTH-1:WIDTH] : acc_sum[WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    hi_d        = hi_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (op[2:1] == 2'b11) begin
            state_d  = MULT;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            hi_d     = ~op[0];
          end else begin
            result_d    = alu_res;
            flags_d     = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
            out_valid_d = 1'b1;
          end
        end
      end
      MULT: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << STEP;
        mplier_d = mplier_q >> STEP;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          result_d    = mul_res;
          flags_d     = {mul_res[WIDTH-1], (mul_res == '0), 2'b00};
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      hi_q        <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      hi_q        <= hi_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = ~in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: a STEP=1 instance checked through a result
// scoreboard plus inline latency/handshake checks, and a STEP=4 instance.
module tb_alu_iter;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, busy;
  logic [2:0]   op;
  logic [W-1:0] a, b, result;
  logic [3:0]   flags;

  logic         in_valid4, in_ready4, out_valid4, busy4;
  logic [2:0]   op4;
  logic [W-1:0] a4, b4, result4;
  logic [3:0]   flags4;

  alu_iter #(.WIDTH(W), .STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .result(result),
    .flags(flags), .busy(busy)
  );

  alu_iter #(.WIDTH(W), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .op(op4), .a(a4), .b(b4), .out_valid(out_valid4), .result(result4),
    .flags(flags4), .busy(busy4)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   fl;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
  endtask

  task automatic push(input logic [W-1:0] r, input logic [3:0] f);
    exp_t e;
    e.res = r;
    e.fl  = f;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every out_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      exp_t e;
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL spurious_out_valid: got result %h with empty queue, expected no out_valid", result);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("[TB] txn result=%h flags=%b (exp %h %b)", result, flags, e.res, e.fl);
        chk("sb_result", result, e.res);
        chk("sb_flags", 32'(flags), 32'(e.fl));
      end
    end
  end

  int lat;
  int bad_ready;
  int ov_count;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; op = '0; a = '0; b = '0;
    in_valid4 = 1'b0; op4 = '0; a4 = '0; b4 = '0;
    tick();
    tick();
    chk("rst_result", result, 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);

    // First request presented together with reset release.
    rst_n = 1'b1;
    send(3'b000, 32'h7FFF_FFFF, 32'h1); push(32'h8000_0000, 4'b1001);
    tick();
    chk("add_ov_out_valid", 32'(out_valid), 32'h1);
    send(3'b001, 32'd5, 32'd5); push(32'h0, 4'b0110);
    tick();
    chk("sub_eq_out_valid", 32'(out_valid), 32'h1);
    send(3'b001, 32'd3, 32'd5); push(32'hFFFF_FFFE, 4'b1000);
    tick();
    chk("sub_neg_out_valid", 32'(out_valid), 32'h1);
    send(3'b000, 32'hFFFF_FFFF, 32'h1); push(32'h0, 4'b0110);
    tick();
    send(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00); push(32'hF000_F000, 4'b1000);
    tick();
    send(3'b011, 32'h0F0F_0000, 32'h0000_00F0); push(32'h0F0F_00F0, 4'b0000);
    tick();
    send(3'b100, 32'h1234_5678, 32'h0); push(32'h0, 4'b0100);
    tick();
    send(3'b101, 32'h1, 32'h1); push(32'h0, 4'b0100);
    tick();
    in_valid = 1'b0;
    tick();
    chk("idle_out_valid", 32'(out_valid), 32'h0);

    // MUL all-ones: low half.
    send(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF); push(32'h0000_0001, 4'b0000);
    tick();
    in_valid = 1'b0;
    lat = 0; bad_ready = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) bad_ready++;
      tick();
      lat++;
    end
    chk("mul_latency", lat, 32);
    chk("mul_ready_low_while_busy", bad_ready, 0);
    chk("mul_ready_at_done", 32'(in_ready), 32'h1);

    // UMULH all-ones: high half.
    send(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF); push(32'hFFFF_FFFE, 4'b1000);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("umulh_latency", lat, 32);

    // ADD held during a MUL; operands change while busy and must be ignored.
    send(3'b111, 32'd3, 32'd7); push(32'd21, 4'b0000);
    tick();
    send(3'b000, 32'd1, 32'd2);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("held_mul_latency", lat, 32);
    chk("held_ready_at_done", 32'(in_ready), 32'h1);
    push(32'd3, 4'b0000);
    tick();
    in_valid = 1'b0;
    chk("held_add_out_valid", 32'(out_valid), 32'h1);
    tick();
    chk("held_add_then_idle", 32'(out_valid), 32'h0);

    // Reset pulsed at multiply cycle 10.
    send(3'b111, 32'd1000, 32'd1000); push(32'd1000000, 4'b0000);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("pre_rst_busy", 32'(busy), 32'h1);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_flags", 32'(flags), 32'h0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    tick();
    rst_n = 1'b1;
    ov_count = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) ov_count++;
    end
    chk("post_rst_no_out_valid", ov_count, 0);
    send(3'b000, 32'd2, 32'd2); push(32'd4, 4'b0000);
    tick();
    in_valid = 1'b0;
    chk("post_rst_add_out_valid", 32'(out_valid), 32'h1);
    tick();

    // STEP=4 instance.
    op4 = 3'b111; a4 = 32'd12345; b4 = 32'd678; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 100) begin
      tick();
      lat++;
    end
    $display("[TB] txn step4 result=%h flags=%b latency=%0d", result4, flags4, lat);
    chk("step4_latency", lat, 8);
    chk("step4_result", result4, 32'h007F_B6F6);
    chk("step4_flags", 32'(flags4), 32'h0);

    tick();
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width.
REQ-002 The block SHALL have parameter STEP, default 1, giving the multiplier bits retired per cycle; legal values are 1, 2, 4 or 8, and WIDTH mod STEP must be 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operation request.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port op, input, 3 bits, with encoding 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 BPASS, 101 reserved, 110 UMULH, 111 MUL.
REQ-008 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a one-cycle pulse marking the result as valid.
REQ-010 The block SHALL have port result, output, WIDTH bits: the registered result.
REQ-011 The block SHALL have port flags, output, 4 bits, ordered {N,Z,C,V} and registered.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a multiply is in progress.

Function
REQ-013 A request SHALL be accepted on a rising edge where in_valid && in_ready are both high; a, b and op SHALL be sampled on that edge.
REQ-014 The FSM SHALL have two states, IDLE and MULT; in_ready SHALL be 1 in IDLE and 0 in MULT, and busy SHALL be the inverse of in_ready.
REQ-015 Single-cycle ops (000–101) accepted at edge e SHALL update result and flags at edge e, and out_valid SHALL be 1 for exactly the following cycle.
REQ-016 Single-cycle ops SHALL give back-to-back throughput of 1 op per cycle.
REQ-017 ADD/SUB SHALL use one adder: SUB is a + ~b + 1, computed at WIDTH+1 bits.
REQ-018 For ADD/SUB, C SHALL be the adder carry-out, so SUB C=1 means a>=b unsigned.
REQ-019 For ADD/SUB, V SHALL be signed overflow.
REQ-020 The AND/ORR/BPASS operations SHALL return a&b, a|b and b respectively.
REQ-021 The reserved op 101 SHALL return 0.
REQ-022 For all operations other than ADD/SUB, C and V SHALL be 0.
REQ-023 For all ops, N SHALL equal result[WIDTH-1] and Z SHALL equal (result==0).
REQ-024 MUL/UMULH accepted at edge e SHALL move the FSM to MULT and clear a 2*WIDTH accumulator and a step counter.
REQ-025 In MULT, the block SHALL perform unsigned shift-add multiplication, consuming STEP bits of b per cycle for N = WIDTH/STEP cycles.
REQ-026 On the edge where the counter equals N-1, the block SHALL write result (MUL: product low WIDTH bits; UMULH: product high WIDTH bits unsigned), update flags, return to IDLE, and make out_valid high for the next cycle.
REQ-027 Multiply latency SHALL be out_valid visible after edge e+N; for WIDTH=32 and STEP=1 this is 32 cycles.
REQ-028 in_ready SHALL be high in the same cycle as the multiply's out_valid, so a new request can be accepted on that cycle's edge.
REQ-029 in_valid during MULT SHALL be ignored, and op, a and b SHALL be don't-care; the operands latched at acceptance SHALL be used throughout.
REQ-030 The step counter SHALL be exactly ceil(log2(N)) bits wide (minimum 1) and SHALL NOT wrap inside one operation.
REQ-031 There is no output backpressure; result and flags SHALL hold their values until the next completion.

Reset
REQ-032 While rst_n=0, the block SHALL immediately force: state=IDLE, result=0, flags=0000, out_valid=0, accumulator and counter=0, in_ready=1, busy=0.
REQ-033 Reset asserted mid-multiply SHALL abort the operation, and no out_valid SHALL be produced for that operation after release.
REQ-034 The first request SHALL be acceptable on the first rising edge after rst_n deasserts.
REQ-035 Illegal STEP/WIDTH combinations SHALL be rejected at elaboration.

Verification
REQ-036 The bench SHALL cover (WIDTH=32, STEP=1): ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, flags 1001, out_valid in the cycle after acceptance.
REQ-037 The bench SHALL cover: SUB a=5, b=5 -> result 0, flags 0110; then SUB a=3, b=5 on the next edge -> result 0xFFFFFFFE, flags 1000, with out_valid high on two consecutive cycles.
REQ-038 The bench SHALL cover: MUL a=b=0xFFFFFFFF -> result 0x00000001, flags 0000, out_valid exactly 32 cycles after acceptance, and in_ready=0 throughout; UMULH with the same operands -> result 0xFFFFFFFE, flags 1000.
REQ-039 The bench SHALL cover: an ADD (a=1, b=2) held on in_valid during a MUL -> the ADD is not accepted until the MUL's out_valid cycle, and the ADD result 3 follows one cycle later.
REQ-040 The bench SHALL cover: rst_n pulsed low at multiply cycle 10 -> outputs immediately reach their reset values, there is no out_valid after release, and the next ADD 2+2 returns 4 normally.
REQ-041 The bench SHALL cover (STEP=4): MUL a=12345, b=678 -> result 0x007FB6F6, out_valid 8 cycles after acceptance.
